// File: rtl/ysyx_ifu_axi.sv
// Instruction-fetch AXI4 read master: one outstanding fetch, optional 2-beat bursts.
// Define YSYX_IFU_AXI_BURST_EN to fetch aligned 8-byte bursts in [0xa0000000, 0xc0000000].
module ysyx_ifu_axi #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ifu_araddr_i,
    input  logic              ifu_arvalid_i,
    input  logic              ifu_required_i,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,
    output logic              ifu_rerr_o,
    output logic [DATA_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state;
    logic              burst;
    logic [DATA_W-1:0] req_addr;

`ifdef YSYX_IFU_AXI_BURST_EN
    assign burst    = (ifu_araddr_i >= DATA_W'(32'ha0000000)) &&
                      (ifu_araddr_i <= DATA_W'(32'hc0000000));
    assign req_addr = burst ? (ifu_araddr_i & ~DATA_W'(4)) : ifu_araddr_i;
`else
    assign burst    = 1'b0;
    assign req_addr = ifu_araddr_i;
`endif

    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign rready  = (state == DATA) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            arvalid      <= 1'b0;
            araddr       <= '0;
            arlen        <= 8'd0;
            ifu_rvalid_o <= 1'b0;
            ifu_rerr_o   <= 1'b0;
            ifu_rdata_o  <= '0;
        end else begin
            ifu_rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ifu_arvalid_i) begin
                        araddr     <= req_addr;
                        arlen      <= burst ? 8'd1 : 8'd0;
                        arvalid    <= 1'b1;
                        ifu_rerr_o <= 1'b0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    // A flushed request still has to finish its AR handshake.
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= ifu_required_i ? DATA : DRAIN;
                    end else if (!ifu_required_i) begin
                        state <= DRAIN;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        if (rresp != 2'b00) ifu_rerr_o <= 1'b1;
                        if (ifu_required_i) begin
                            ifu_rdata_o  <= rdata;
                            ifu_rvalid_o <= 1'b1;
                        end
                        if (rlast)                state <= IDLE;
                        else if (!ifu_required_i) state <= DRAIN;
                    end else if (!ifu_required_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Beats only count once the address phase has completed.
                    if (arvalid) begin
                        if (arready) arvalid <= 1'b0;
                    end else if (rvalid) begin
                        if (rresp != 2'b00) ifu_rerr_o <= 1'b1;
                        if (rlast) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_ifu_axi.sv
// Directed bench for ysyx_ifu_axi: bench-side AXI slave, expected-word queue and
// per-cycle AR/R checker; burst expectations follow YSYX_IFU_AXI_BURST_EN.
module tb_ysyx_ifu_axi;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr_i;
    logic        ifu_arvalid_i, ifu_required_i;
    logic [31:0] ifu_rdata_o;
    logic        ifu_rvalid_o, ifu_rerr_o;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    ysyx_ifu_axi #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr_i(ifu_araddr_i), .ifu_arvalid_i(ifu_arvalid_i),
        .ifu_required_i(ifu_required_i), .ifu_rdata_o(ifu_rdata_o),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rerr_o(ifu_rerr_o),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ar_hs, pulses, first_cyc, req_cyc;
    bit ar_open = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [7:0]  exp_len = '0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle checker: AR fields against the open request, delivered words against the queue.
    always @(negedge clk) begin
        if (rst) begin
            if (arvalid) begin
                chk("ar_unexpected", 64'(arvalid), 64'(ar_open));
                chk("araddr", 64'(araddr), 64'(exp_addr));
                chk("arlen", 64'(arlen), 64'(exp_len));
                chk("arsize_arburst", 64'({arsize, arburst}), 64'({3'b010, 2'b01}));
                if (arready) ar_hs++;
            end
            if (ifu_rvalid_o) begin
                pulses++;
                if (first_cyc < 0) first_cyc = cyc;
                if (exp_q.size() == 0) chk("rdata_extra", 64'(ifu_rvalid_o), 64'(0));
                else chk("rdata", 64'(ifu_rdata_o), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_arvalid"}, 64'(arvalid), 64'(0));
        chk({tag, "_rready"}, 64'(rready), 64'(0));
        chk({tag, "_ifu_rvalid"}, 64'(ifu_rvalid_o), 64'(0));
        chk({tag, "_ifu_rerr"}, 64'(ifu_rerr_o), 64'(0));
        chk({tag, "_ifu_rdata"}, 64'(ifu_rdata_o), 64'(0));
        chk({tag, "_araddr"}, 64'(araddr), 64'(0));
        chk({tag, "_arlen"}, 64'(arlen), 64'(0));
    endtask

    // flush: 0 none, 1 drop ifu_required_i after AR handshake, 2 drop it during ADDR.
    task automatic fetch(input logic [31:0] addr, input int ar_wait, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [1:0] resp, input int flush);
        bit burst;
        int nb;
        burst = 1'b0;
`ifdef YSYX_IFU_AXI_BURST_EN
        burst = (addr >= 32'ha0000000) && (addr <= 32'hc0000000);
`endif
        exp_addr = burst ? (addr & ~32'd4) : addr;
        exp_len  = burst ? 8'd1 : 8'd0;
        nb       = burst ? 2 : 1;
        if (flush == 0) begin
            exp_q.push_back(w0);
            if (burst) exp_q.push_back(w1);
        end
        ar_hs = 0; pulses = 0; first_cyc = -1;
        ifu_required_i = 1'b1; ifu_araddr_i = addr; ifu_arvalid_i = 1'b1;
        ar_open = 1'b1; req_cyc = cyc;
        @(posedge clk); #1;
        ifu_arvalid_i = 1'b0; ifu_araddr_i = 32'h0bad0000;
        if (flush == 2) ifu_required_i = 1'b0;
        for (int i = 0; i < ar_wait; i++) begin
            ifu_arvalid_i = i[0];
            if (flush != 2) begin
                rvalid = 1'b1; rdata = 32'hdead0000 | i; rlast = 1'b1; rresp = 2'b00;
                #1 chk("rready_in_addr", 64'(rready), 64'(0));
            end
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; ifu_arvalid_i = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0; ar_open = 1'b0;
        if (flush == 1) ifu_required_i = 1'b0;
        for (int b = 0; b < nb; b++) begin
            rvalid = 1'b1; rdata = (b == 0) ? w0 : w1; rlast = (b == nb - 1); rresp = resp;
            ifu_arvalid_i = rlast;
            #1 chk("rready_beat", 64'(rready), 64'(1));
            @(posedge clk); #1;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; ifu_arvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ar_handshakes", 64'(ar_hs), 64'(1));
        chk("pulse_count", 64'(pulses), 64'((flush != 0) ? 0 : nb));
        chk("rerr", 64'(ifu_rerr_o), 64'(resp != 2'b00));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        if (flush == 0) chk("latency", 64'(first_cyc - req_cyc), 64'(3 + ar_wait));
    endtask

    initial begin
        rst = 1'b0; ifu_araddr_i = '0; ifu_arvalid_i = 1'b0; ifu_required_i = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        #12 check_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        fetch(32'h30000000, 0, 32'h00000413, 32'h0, 2'b00, 0);
        chk("lit_rdata_0413", 64'(ifu_rdata_o), 64'h413);
        fetch(32'ha0000004, 0, 32'h11111111, 32'h22222222, 2'b00, 0);
`ifdef YSYX_IFU_AXI_BURST_EN
        chk("lit_burst_last_word", 64'(ifu_rdata_o), 64'h22222222);
`else
        chk("lit_single_word", 64'(ifu_rdata_o), 64'h11111111);
`endif
        fetch(32'h80000010, 5, 32'h12345678, 32'h0, 2'b00, 0);
        fetch(32'ha0000008, 0, 32'h33333333, 32'h44444444, 2'b00, 1);
        chk("lit_flush_keeps_data", 64'(ifu_rdata_o), 64'h12345678);
        fetch(32'h30000004, 0, 32'hdeadbeef, 32'h0, 2'b10, 0);
        chk("lit_err_data", 64'(ifu_rdata_o), 64'hdeadbeef);
        fetch(32'h30000008, 1, 32'h00100073, 32'h0, 2'b00, 0);
        fetch(32'hb0000000, 2, 32'h55555555, 32'h66666666, 2'b00, 2);
        fetch(32'hc0000000, 0, 32'h77777777, 32'h88888888, 2'b00, 0);

        // Reset in the middle of DATA.
        exp_addr = 32'h30000100; exp_len = 8'd0; ar_hs = 0;
        ifu_required_i = 1'b1; ifu_araddr_i = 32'h30000100; ifu_arvalid_i = 1'b1; ar_open = 1'b1;
        @(posedge clk); #1;
        ifu_arvalid_i = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0; ar_open = 1'b0;
        chk("mid_data_rready", 64'(rready), 64'(1));
        rst = 1'b0;
        #1 check_all_zero("mid_reset");
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle_rready", 64'(rready), 64'(0));
        fetch(32'h30000200, 0, 32'hcafef00d, 32'h0, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
